// File: rtl/conv_window_feeder.sv
// Window feeder for a convolution layer: buffers K rows of a raster activation
// stream and writes every complete KxK window into the CIM crossbar input registers.
module conv_window_feeder #(
    parameter  int img_width     = 8,
    parameter  int img_height    = 8,
    parameter  int kernel_size   = 3,
    parameter  int channels      = 16,
    parameter  int xbar_size     = 256,
    parameter  int datatype_size = 8,
    localparam int win_len       = kernel_size * kernel_size * channels,
    localparam int v_cim_tiles   = (win_len + xbar_size - 1) / xbar_size
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           i_valid,
    input  logic [datatype_size-1:0]                       i_data,
    output logic                                           o_ready,
    input  logic                                           i_cim_busy,
    output logic                                           o_cim_we,
    output logic [$clog2(xbar_size)-1:0]                   o_cim_addr,
    output logic [v_cim_tiles-1:0][datatype_size-1:0]      o_cim_data,
    output logic                                           o_cim_start,
    output logic                                           o_busy,
    output logic                                           o_frame_done
);

    localparam int AW       = $clog2(xbar_size);
    localparam int XFER_LEN = (v_cim_tiles > 1) ? xbar_size : win_len;
    localparam int DEPTH    = kernel_size * img_width * channels;
    localparam int BAW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int XW       = (img_width > 1) ? $clog2(img_width) : 1;
    localparam int YW       = (img_height > 1) ? $clog2(img_height) : 1;
    localparam int CW       = (channels > 1) ? $clog2(channels) : 1;
    localparam int SW       = (kernel_size > 1) ? $clog2(kernel_size) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(img_width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(img_height - 1);
    localparam logic [CW-1:0] C_LAST = CW'(channels - 1);
    localparam logic [SW-1:0] S_LAST = SW'(kernel_size - 1);
    localparam logic [AW-1:0] A_LAST = AW'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        FILL,
        WAIT,
        XFER,
        START
    } state_t;

    state_t state;

    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic [CW-1:0] px_c;
    logic [SW-1:0] wr_slot;
    logic [XW-1:0] win_x;
    logic [SW-1:0] win_slot;
    logic          win_last;

    logic [datatype_size-1:0] line_buf [DEPTH];

    logic                                      accept;
    logic                                      win_done;
    logic [BAW-1:0]                            wr_idx;
    logic [v_cim_tiles-1:0][datatype_size-1:0] rd_data;

    function automatic logic [BAW-1:0] buf_idx(input int unsigned slot, input int unsigned xpos,
                                               input int unsigned ch);
        return BAW'((slot * 32'(img_width) + xpos) * 32'(channels) + ch);
    endfunction

    assign accept   = (state == FILL) && o_ready && i_valid;
    assign win_done = accept && (px_c == C_LAST)
                      && (32'(px_x) >= 32'(kernel_size - 1))
                      && (32'(px_y) >= 32'(kernel_size - 1));
    assign wr_idx   = buf_idx(32'(wr_slot), 32'(px_x), 32'(px_c));

    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            line_buf[wr_idx] <= i_data;
        end
    end

    // Data for the next write address. On the completing accept the window origin
    // is taken from the live counters, and the element being written is forwarded.
    always_comb begin
        int unsigned rd_a, base_x, base_slot, e, ky, kx, ch, row;
        logic [BAW-1:0] idx;
        rd_data   = '0;
        rd_a      = (state == XFER) ? 32'(o_cim_addr) + 32'd1 : 32'd0;
        base_x    = (state == FILL) ? 32'(px_x) - 32'(kernel_size - 1) : 32'(win_x);
        base_slot = (state == FILL) ? (32'(wr_slot) + 32'd1) % 32'(kernel_size) : 32'(win_slot);
        e         = 0;
        ky        = 0;
        kx        = 0;
        ch        = 0;
        row       = 0;
        idx       = '0;
        for (int unsigned t = 0; t < v_cim_tiles; t++) begin
            e = t * 32'(xbar_size) + rd_a;
            if (e < 32'(win_len)) begin
                ky  = e / 32'(kernel_size * channels);
                kx  = (e / 32'(channels)) % 32'(kernel_size);
                ch  = e % 32'(channels);
                row = (base_slot + ky) % 32'(kernel_size);
                idx = buf_idx(row, base_x + kx, ch);
                rd_data[t] = (accept && idx == wr_idx) ? i_data : line_buf[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            o_ready      <= 1'b0;
            o_cim_we     <= 1'b0;
            o_cim_addr   <= '0;
            o_cim_data   <= '0;
            o_cim_start  <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            px_x         <= '0;
            px_y         <= '0;
            px_c         <= '0;
            wr_slot      <= '0;
            win_x        <= '0;
            win_slot     <= '0;
            win_last     <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    o_ready <= 1'b1;
                    if (accept) begin
                        // The last window completes on the last element of the frame,
                        // so the natural raster wrap already restarts at (0,0,0).
                        if (px_c == C_LAST) begin
                            px_c <= '0;
                            if (px_x == X_LAST) begin
                                px_x <= '0;
                                if (px_y == Y_LAST) begin
                                    px_y    <= '0;
                                    wr_slot <= '0;
                                end else begin
                                    px_y    <= px_y + 1'b1;
                                    wr_slot <= (wr_slot == S_LAST) ? '0 : wr_slot + 1'b1;
                                end
                            end else begin
                                px_x <= px_x + 1'b1;
                            end
                        end else begin
                            px_c <= px_c + 1'b1;
                        end
                        if (win_done) begin
                            win_x    <= XW'(32'(px_x) - 32'(kernel_size - 1));
                            win_slot <= SW'((32'(wr_slot) + 32'd1) % 32'(kernel_size));
                            win_last <= (px_x == X_LAST) && (px_y == Y_LAST);
                            o_ready  <= 1'b0;
                            o_busy   <= 1'b1;
                            if (i_cim_busy) begin
                                state <= WAIT;
                            end else begin
                                state      <= XFER;
                                o_cim_we   <= 1'b1;
                                o_cim_addr <= '0;
                                o_cim_data <= rd_data;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (!i_cim_busy) begin
                        state      <= XFER;
                        o_cim_we   <= 1'b1;
                        o_cim_addr <= '0;
                        o_cim_data <= rd_data;
                    end
                end
                XFER: begin
                    if (o_cim_addr == A_LAST) begin
                        state        <= START;
                        o_cim_we     <= 1'b0;
                        o_cim_addr   <= '0;
                        o_cim_data   <= '0;
                        o_cim_start  <= 1'b1;
                        o_frame_done <= win_last;
                    end else begin
                        o_cim_addr <= o_cim_addr + 1'b1;
                        o_cim_data <= rd_data;
                    end
                end
                START: begin
                    state        <= FILL;
                    o_cim_start  <= 1'b0;
                    o_frame_done <= 1'b0;
                    o_busy       <= 1'b0;
                    o_ready      <= 1'b1;
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: 4x4x2 maps, K=3, one DUT with a single tile and one
// with 8-row crossbars (3 tiles), driven from a table of scenarios.
module tb_conv_window_feeder;

    localparam int W = 4, H = 4, K = 3, C = 2;
    localparam int WL = K * K * C, NWX = W - K + 1, NW = NWX * (H - K + 1), FRAME = W * H * C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, valid_a, busy_a, ready_a, we_a, start_a, obusy_a, done_a;
    logic [7:0]      data_a, addr_a;
    logic [0:0][7:0] cdata_a;
    logic            rst_b, valid_b, busy_b, ready_b, we_b, start_b, obusy_b, done_b;
    logic [7:0]      data_b;
    logic [2:0]      addr_b;
    logic [2:0][7:0] cdata_b;

    conv_window_feeder #(.img_width(W), .img_height(H), .kernel_size(K), .channels(C),
                         .xbar_size(256), .datatype_size(8)) dut_a (
        .clk(clk), .rst(rst_a), .i_valid(valid_a), .i_data(data_a), .o_ready(ready_a),
        .i_cim_busy(busy_a), .o_cim_we(we_a), .o_cim_addr(addr_a), .o_cim_data(cdata_a),
        .o_cim_start(start_a), .o_busy(obusy_a), .o_frame_done(done_a));

    conv_window_feeder #(.img_width(W), .img_height(H), .kernel_size(K), .channels(C),
                         .xbar_size(8), .datatype_size(8)) dut_b (
        .clk(clk), .rst(rst_b), .i_valid(valid_b), .i_data(data_b), .o_ready(ready_b),
        .i_cim_busy(busy_b), .o_cim_we(we_b), .o_cim_addr(addr_b), .o_cim_data(cdata_b),
        .o_cim_start(start_b), .o_busy(obusy_b), .o_frame_done(done_b));

    typedef struct {
        int sel;
        bit rand_v;
        bit busy_m;
        bit rst_m;
        int frames;
        int exp_wins;
        int exp_done;
    } scen_t;

    int errors = 0, checks = 0, cyc = 0;
    int sel = 0, acc = 0, max_acc = 0, win = 0, wrc = 0, ndone = 0, busy_left = 0, drop_cyc = -10;
    bit rand_v = 0, busy_m = 0, busy_done = 0, rst_arm = 0, rst_chk = 0, seen_we = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream value = global element index; window w of the run lies in frame w/NW.
    function automatic int model(input int w, input int e);
        int f, wi, wx, wy, ky, kx, c;
        f  = w / NW;
        wi = w % NW;
        wx = wi % NWX;
        wy = wi / NWX;
        ky = e / (K * C);
        kx = (e / C) % K;
        c  = e % C;
        return (f * FRAME + ((wy + ky) * W + wx + kx) * C + c) % 256;
    endfunction

    task automatic step();
        logic rdy, we, st, bz, fd, bsy, v, nb;
        int ad, L, xb, nt, e;
        logic [2:0][7:0] cd;
        @(negedge clk);
        cyc++;
        if (sel == 0) begin
            rdy = ready_a; we = we_a; st = start_a; bz = obusy_a; fd = done_a; bsy = busy_a;
            ad = 32'(addr_a); cd = {16'h0, cdata_a}; L = WL; xb = 256; nt = 1;
        end else begin
            rdy = ready_b; we = we_b; st = start_b; bz = obusy_b; fd = done_b; bsy = busy_b;
            ad = 32'(addr_b); cd = cdata_b; L = 8; xb = 8; nt = 3;
        end
        if (rst_chk) begin
            chk("outputs cleared by mid-transfer reset",
                (rdy | we | st | bz | fd | (ad != 0) | (cd != '0)) ? 1 : 0, 0);
            rst_chk = 0; rst_a = 1'b0;
            acc = 0; win = 0; wrc = 0; ndone = 0; seen_we = 0;
        end else begin
            if (we) begin
                if (!seen_we) begin
                    chk("accepts before first write", acc, 22);
                    if (busy_m) chk("first write one cycle after busy falls", cyc, drop_cyc + 1);
                    seen_we = 1;
                end
                chk("write addr", ad, wrc);
                chk("ready low during write", int'(rdy), 0);
                chk("busy high during write", int'(bz), 1);
                for (int t = 0; t < nt; t++) begin
                    e = t * xb + wrc;
                    chk($sformatf("win %0d tile %0d addr %0d data", win, t, wrc),
                        int'(cd[t]), (e < WL) ? model(win, e) : 0);
                end
                if (rst_arm && ad == 5) begin
                    rst_arm = 0; rst_chk = 1; rst_a = 1'b1;
                end
                wrc++;
            end
            if (st || fd) begin
                chk("writes before start", st ? wrc : -1, L);
                chk("frame_done on last window", int'(fd), (win % NW == NW - 1) ? 1 : 0);
                if (fd) ndone++;
                win++;
                wrc = 0;
            end
            if (busy_m && bsy && acc >= 22 && !seen_we)
                chk("wait holds ready and write low", int'(rdy | we), 0);
        end
        v = 1'b0;
        if (!(sel == 0 && rst_a) && acc < max_acc) v = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sel == 0) begin
            valid_a = v; data_a = rdy ? 8'(acc) : 8'hA5;
        end else begin
            valid_b = v; data_b = rdy ? 8'(acc) : 8'hA5;
        end
        if (v && rdy) acc++;
        if (busy_m && !busy_done && acc == 20) begin
            busy_left = 20; busy_done = 1;
        end
        nb = (busy_left > 0);
        if (!nb && bsy) drop_cyc = cyc;
        if (busy_left > 0) busy_left--;
        if (sel == 0) busy_a = nb; else busy_b = nb;
    endtask

    task automatic do_reset(input bit check);
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0; busy_a = 1'b0; busy_b = 1'b0;
        data_a = '0; data_b = '0;
        repeat (2) @(negedge clk);
        if (check) begin
            chk("reset outputs dut_a", (ready_a | we_a | start_a | obusy_a | done_a
                | (addr_a != 0) | (cdata_a != '0)) ? 1 : 0, 0);
            chk("reset outputs dut_b", (ready_b | we_b | start_b | obusy_b | done_b
                | (addr_b != 0) | (cdata_b != '0)) ? 1 : 0, 0);
        end
        rst_a = 1'b0; rst_b = 1'b0;
        if (check) begin
            @(negedge clk);
            chk("ready rises after reset", int'(ready_a), 1);
            chk("idle busy after reset", int'(obusy_a), 0);
        end
    endtask

    task automatic run(input int idx, input scen_t s);
        sel = s.sel; rand_v = s.rand_v; busy_m = s.busy_m; rst_arm = s.rst_m;
        max_acc = FRAME * s.frames;
        acc = 0; win = 0; wrc = 0; ndone = 0; seen_we = 0;
        busy_left = 0; busy_done = 0; drop_cyc = -10; rst_chk = 0;
        do_reset(1'b0);
        for (int n = 0; n < 3000 && win < s.exp_wins; n++) step();
        repeat (4) step();
        chk($sformatf("scenario %0d start count", idx), win, s.exp_wins);
        chk($sformatf("scenario %0d frame_done count", idx), ndone, s.exp_done);
    endtask

    initial begin
        scen_t tbl[6];
        tbl[0] = '{sel: 0, rand_v: 0, busy_m: 0, rst_m: 0, frames: 1, exp_wins: 4, exp_done: 1};
        tbl[1] = '{sel: 1, rand_v: 0, busy_m: 0, rst_m: 0, frames: 1, exp_wins: 4, exp_done: 1};
        tbl[2] = '{sel: 0, rand_v: 0, busy_m: 1, rst_m: 0, frames: 1, exp_wins: 4, exp_done: 1};
        tbl[3] = '{sel: 0, rand_v: 1, busy_m: 0, rst_m: 0, frames: 1, exp_wins: 4, exp_done: 1};
        tbl[4] = '{sel: 0, rand_v: 0, busy_m: 0, rst_m: 1, frames: 1, exp_wins: 4, exp_done: 1};
        tbl[5] = '{sel: 0, rand_v: 0, busy_m: 0, rst_m: 0, frames: 2, exp_wins: 8, exp_done: 2};
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) run(i, tbl[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
